// File: rtl/mem_responder.sv
// Single-port 16x32 memory responder with fixed wait-state latency and one-cycle ready pulse.
// Optional request statistics (rd_count/wr_count) are built when MEM_RESPONDER_STATS_EN is defined.
module mem_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        InstRead,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
`ifdef MEM_RESPONDER_STATS_EN
   ,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic [3:0]  cnt;
   logic [3:0]  cnt_next;
   logic        accept;
   logic        op_read;
   logic        op_multi;
   logic [5:0]  lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] mem [DEPTH];

   logic        cur_read;
   logic        cur_multi;
   logic [5:0]  cur_addr;
   logic [31:0] cur_wdata;
   logic        cur_mis;
   logic        enter_resp;
   logic        unused_addr;

   assign unused_addr = ^addr[31:6];

   // Next-state and wait counter
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (InstRead || MemRead || MemWrite) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_next = RESP;
                  cnt_next   = 4'd0;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WAIT_CYCLES[3:0];
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = RESP;
            end else begin
               state_next = WAIT;
            end
         end
         RESP: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // With zero wait states the response is formed from the live inputs in the accepting cycle
   always_comb begin
      if (accept) begin
         cur_read  = InstRead | MemRead;
         cur_multi = ({1'b0, InstRead} + {1'b0, MemRead} + {1'b0, MemWrite}) > 2'd1;
         cur_addr  = addr[5:0];
         cur_wdata = wdata;
      end else begin
         cur_read  = op_read;
         cur_multi = op_multi;
         cur_addr  = lat_addr;
         cur_wdata = lat_wdata;
      end
      cur_mis    = (cur_addr[1:0] != 2'b00);
      enter_resp = (state_next == RESP) && (state != RESP);
   end

   // Control state, request latch and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         op_read   <= 1'b0;
         op_multi  <= 1'b0;
         lat_addr  <= 6'd0;
         lat_wdata <= 32'd0;
         ready     <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         busy  <= (state_next != IDLE);
         if (accept) begin
            op_read   <= cur_read;
            op_multi  <= cur_multi;
            lat_addr  <= cur_addr;
            lat_wdata <= cur_wdata;
         end
         if (enter_resp) begin
            ready <= 1'b1;
            err   <= cur_multi | cur_mis;
            if (cur_read) begin
               rdata <= cur_mis ? 32'd0 : mem[cur_addr[5:2]];
            end
         end else begin
            ready <= 1'b0;
            err   <= 1'b0;
         end
      end
   end

   // Storage array; misaligned stores are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (enter_resp && !cur_read && !cur_mis) begin
         mem[cur_addr[5:2]] <= cur_wdata;
      end
   end

`ifdef MEM_RESPONDER_STATS_EN
   // Saturating counts of error-free responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (ready && !err) begin
         if (op_read && rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
         end
         if (!op_read && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two instances (WAIT_CYCLES=2 and 0) against a word-array reference model.
module tb_mem_responder;

   logic        clk;
   logic        rst;
   logic        ir [2];
   logic        mr [2];
   logic        mw [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic [31:0] rd_o [2];
   logic        rdy_o [2];
   logic        bsy_o [2];
   logic        er_o [2];
`ifdef MEM_RESPONDER_STATS_EN
   logic [15:0] rc_o [2];
   logic [15:0] wc_o [2];
`endif

   logic [31:0] mdl [2][16];
   logic [31:0] exp_rd [2];
   int          rdc [2];
   int          wrc [2];
   int          checks;
   int          errors;

   mem_responder #(.WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rst(rst), .InstRead(ir[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
      .addr(ad[0]), .wdata(wd[0]), .rdata(rd_o[0]), .ready(rdy_o[0]), .busy(bsy_o[0]), .err(er_o[0])
`ifdef MEM_RESPONDER_STATS_EN
      , .rd_count(rc_o[0]), .wr_count(wc_o[0])
`endif
   );

   mem_responder #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .InstRead(ir[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
      .addr(ad[1]), .wdata(wd[1]), .rdata(rd_o[1]), .ready(rdy_o[1]), .busy(bsy_o[1]), .err(er_o[1])
`ifdef MEM_RESPONDER_STATS_EN
      , .rd_count(rc_o[1]), .wr_count(wc_o[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) mdl[d][i] = 32'd0;
         exp_rd[d] = 32'd0;
         rdc[d] = 0;
         wrc[d] = 0;
      end
   endtask

   // One request on instance d; optional noise strobes while busy must be ignored
   task automatic req(input int d, input logic i_r, input logic m_r, input logic m_w,
                      input logic [31:0] a, input logic [31:0] w, input bit noise);
      int          lat;
      bit          is_read;
      bit          e;
      logic [31:0] ev;
      lat     = (d == 0) ? 2 : 0;
      is_read = i_r | m_r;
      e       = ((int'(i_r) + int'(m_r) + int'(m_w)) > 1) || (a[1:0] != 2'b00);
      if (is_read) begin
         exp_rd[d] = (a[1:0] != 2'b00) ? 32'd0 : mdl[d][a[5:2]];
         if (!e) rdc[d]++;
      end else begin
         if (a[1:0] == 2'b00) mdl[d][a[5:2]] = w;
         if (!e) wrc[d]++;
      end
      ev = {31'd0, e};
      @(negedge clk);
      ir[d] = i_r; mr[d] = m_r; mw[d] = m_w; ad[d] = a; wd[d] = w;
      @(posedge clk); #1;
      ir[d] = 1'b0; mr[d] = 1'b0; mw[d] = 1'b0;
      if (noise) begin
         mw[d] = 1'b1;
         ad[d] = {26'd0, a[5:2] ^ 4'd1, 2'b00};
         wd[d] = $urandom;
      end
      for (int c = 0; c <= lat; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         chk("ready_timing", {31'd0, rdy_o[d]}, {31'd0, (c == lat)});
         chk("busy_active", {31'd0, bsy_o[d]}, 32'd1);
         if (c < lat) chk("err_outside_resp", {31'd0, er_o[d]}, 32'd0);
      end
      chk("resp_err", {31'd0, er_o[d]}, ev);
      chk("resp_rdata", rd_o[d], exp_rd[d]);
      @(posedge clk); #1;
      mw[d] = 1'b0;
      chk("ready_single", {31'd0, rdy_o[d]}, 32'd0);
      chk("busy_idle", {31'd0, bsy_o[d]}, 32'd0);
      chk("err_idle", {31'd0, er_o[d]}, 32'd0);
   endtask

   initial begin
      logic [2:0]  s;
      logic [31:0] a;
      checks = 0;
      errors = 0;
      for (int d = 0; d < 2; d++) begin
         ir[d] = 1'b0; mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
      end
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", {31'd0, rdy_o[d]}, 32'd0);
         chk("rst_busy", {31'd0, bsy_o[d]}, 32'd0);
         chk("rst_err", {31'd0, er_o[d]}, 32'd0);
         chk("rst_rdata", rd_o[d], 32'd0);
      end
      rst = 1'b0;

      // Directed scenarios
      req(0, 1'b0, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      chk("dir_rd_deadbeef", rd_o[0], 32'hDEADBEEF);
      req(1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h12345678, 1'b0);
      req(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0);
      chk("dir_alias", rd_o[1], 32'h12345678);
      req(0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0);
      chk("dir_prio_rdata", rd_o[0], 32'h0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("dir_prio_nowrite", rd_o[0], 32'h0);
      req(0, 1'b0, 1'b0, 1'b1, 32'h6, 32'hAAAA5555, 1'b0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      chk("dir_misaligned_nowrite", rd_o[0], 32'h0);
      req(0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 1'b1);
      req(0, 1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("dir_noise_ignored", rd_o[0], 32'h0BADF00D);

      // Randomized traffic on both instances
      for (int n = 0; n < 60; n++) begin
         s = 3'($urandom_range(1, 7));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1 && s != 3'b001) s = 3'b001;
         req(n % 2, s[2], s[1], s[0], a, $urandom, ($urandom_range(0, 4) == 0));
      end

      // Reset in the middle of a pending write
      @(negedge clk);
      mw[0] = 1'b1; ad[0] = 32'hC; wd[0] = 32'h55AA55AA;
      @(posedge clk); #1;
      mw[0] = 1'b0;
      chk("pre_rst_busy", {31'd0, bsy_o[0]}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("midrst_busy", {31'd0, bsy_o[0]}, 32'd0);
         chk("midrst_ready", {31'd0, rdy_o[0]}, 32'd0);
         chk("midrst_rdata", rd_o[0], 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      req(0, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
      chk("post_rst_read", rd_o[0], 32'h0);

      // Counter scenario: 3 good reads, 2 good writes, 1 misaligned read
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      req(0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
      req(0, 1'b0, 1'b0, 1'b1, 32'h24, 32'h22222222, 1'b0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      req(0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 1'b0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0);
      req(0, 1'b0, 1'b1, 1'b0, 32'h23, 32'h0, 1'b0);
      chk("misaligned_read_zero", rd_o[0], 32'h0);
`ifdef MEM_RESPONDER_STATS_EN
      chk("rd_count", {16'd0, rc_o[0]}, 32'(rdc[0]));
      chk("wr_count", {16'd0, wc_o[0]}, 32'(wrc[0]));
      chk("rd_count_3", {16'd0, rc_o[0]}, 32'd3);
      chk("wr_count_2", {16'd0, wc_o[0]}, 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of wait-state cycles (legal range 0..15) between accepting a request and asserting ready.
REQ-002 Parameter DEPTH, fixed at 16: word count of the internal array, 32 bits per word.
REQ-003 Ports: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Ports: rst  in  1  asynchronous, active-high reset.
REQ-005 Ports: InstRead  in  1  instruction-fetch read strobe from the control unit.
REQ-006 Ports: MemRead  in  1  data-load read strobe.
REQ-007 Ports: MemWrite  in  1  data-store write strobe.
REQ-008 Ports: addr  in  32  byte address; word index is addr[5:2], and addr[31:6] is ignored (aliasing).
REQ-009 Ports: wdata  in  32  store data.
REQ-010 Ports: rdata  out  32  registered read data.
REQ-011 Ports: ready  out  1  one-cycle response pulse.
REQ-012 Ports: busy  out  1  high whenever state is not IDLE.
REQ-013 Ports: err  out  1  error qualifier, valid only while ready is high.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP; busy SHALL be high in WAIT and RESP.
REQ-015 IDLE: on a rising edge with any strobe high, the block SHALL latch the operation, addr[5:0] and wdata, then go to WAIT with the counter set to WAIT_CYCLES, or go directly to RESP if WAIT_CYCLES=0.
REQ-016 WAIT: the counter SHALL decrement each cycle; on the edge where it reaches 0, the FSM SHALL go to RESP.
REQ-017 Latency: for a request sampled at edge k, ready SHALL be high only in the cycle after edge k+WAIT_CYCLES, for exactly one cycle.
REQ-018 RESP SHALL return to IDLE unconditionally at the next edge; no request is accepted while in RESP.
REQ-019 Strobes arriving while busy is high SHALL be ignored, with no queuing.
REQ-020 Priority SHALL be InstRead > MemRead > MemWrite; when two or more strobes are sampled together, only the highest-priority one is serviced and err=1 in its response.
REQ-021 Reads: rdata SHALL load mem[index] on the edge entering RESP and hold that value until the next read response.
REQ-022 Writes: mem[index] SHALL be written with the latched wdata on the edge entering RESP; rdata is unchanged by a write.
REQ-023 Misaligned access (latched addr[1:0]≠0): there SHALL be no array access and no write, rdata loads 0 for a read, and err=1.
REQ-024 err SHALL be 0 outside RESP.

Reset
REQ-025 While rst is high: state=IDLE, counter=0, ready=0, busy=0, err=0, rdata=0, and all 16 array words=0.
REQ-026 Reset asserted mid-operation SHALL abort the pending request; no write is committed and no ready is produced.
REQ-027 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 With macro MEM_RESPONDER_STATS_EN defined, the block SHALL add output ports rd_count[15:0] and wr_count[15:0], both reset to 0, which increment by 1 on each RESP cycle of an error-free read or write respectively and saturate at 0xFFFF.
REQ-029 Without MEM_RESPONDER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-030 WAIT_CYCLES=2: MemWrite addr=0x8, wdata=0xDEADBEEF, then MemRead addr=0x8 -> each ready pulses exactly 2 cycles after its sampling edge; read rdata=0xDEADBEEF, err=0.
REQ-031 WAIT_CYCLES=0: InstRead addr=0x44 after writing 0x12345678 to addr=0x4 -> ready one cycle after sampling, rdata=0x12345678 (aliasing).
REQ-032 InstRead and MemWrite high together, addr=0x0, wdata=0xFFFFFFFF -> read serviced with err=1, mem[0] stays 0, rdata=0.
REQ-033 MemWrite addr=0x6, wdata=0xAAAA5555 -> err=1 and no write; a subsequent MemRead addr=0x4 returns 0.
REQ-034 Assert rst during WAIT of a MemWrite to addr=0xC -> no ready; MemRead addr=0xC after reset returns 0; busy=0 throughout reset.
REQ-035 With MEM_RESPONDER_STATS_EN: 3 good reads, 2 good writes and 1 misaligned read -> rd_count=3, wr_count=2.
